// File: rtl/instr_mem_loader_pkg.sv
// Shared widths for the instruction-memory loader.
// WORD and INSTR_LEN fall back to 32 bits when the shared constants header has not defined them.
`ifndef WORD
`define WORD 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

package instr_mem_loader_pkg;
  localparam int WORD_W          = `WORD;
  localparam int INSTR_W         = `INSTR_LEN;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_INSTR = INSTR_W / BYTE_W;
  localparam int LANE_IDX_W      = $clog2(BYTES_PER_INSTR);
  localparam int CNT_W           = 16;

  // A session length is legal when it is non-zero and fits the memory.
  function automatic logic word_count_ok(input logic [CNT_W-1:0] wc, input int max_words);
    logic [CNT_W:0] max_ext;
    max_ext = (CNT_W+1)'(max_words);
    return (wc != '0) && ({1'b0, wc} <= max_ext);
  endfunction
endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Assembles one instruction from a little-endian byte stream: byte k lands in lane k.
// last is high while the next load completes the word.
module byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [BYTE_W-1:0]  byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               last
);

  logic [LANE_IDX_W-1:0] count_reg;
  logic [BYTE_W-1:0]     lane_reg [BYTES_PER_INSTR];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_INSTR; gi++) begin : g_lane
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_reg[gi] <= '0;
        end else if (clr) begin
          lane_reg[gi] <= '0;
        end else if (load && (count_reg == LANE_IDX_W'(gi))) begin
          lane_reg[gi] <= byte_in;
        end
      end
      assign word[BYTE_W*gi +: BYTE_W] = lane_reg[gi];
    end
  endgenerate

  assign last = (count_reg == LANE_IDX_W'(BYTES_PER_INSTR - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program from a byte stream into instruction memory while holding the CPU fetch stage.
// Session: COLLECT four bytes, WRITE the word, repeat; RELEASE pulses done and frees the CPU.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_BASE = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   word_count,
  input  logic               byte_valid,
  input  logic [BYTE_W-1:0]  byte_data,
  output logic               byte_ready,
  output logic               wr_en,
  output logic [WORD_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [WORD_W-1:0] BASE = WORD_W'(ADDR_BASE);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] index_reg, index_next;
  logic             error_reg, error_next;

  logic               pk_clr;
  logic               pk_load;
  logic               pk_last;
  logic [INSTR_W-1:0] pk_word;

  byte_packer u_packer (
    .clk     (clk),
    .rst     (reset),
    .clr     (pk_clr),
    .load    (pk_load),
    .byte_in (byte_data),
    .word    (pk_word),
    .last    (pk_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      index_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      index_reg <= index_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    index_next = index_reg;
    error_next = 1'b0;
    pk_clr     = 1'b0;
    pk_load    = 1'b0;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    done       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          if (word_count_ok(word_count, MAX_WORDS)) begin
            state_next = COLLECT;
            count_next = word_count;
            index_next = '0;
            pk_clr     = 1'b1;
          end else begin
            error_next = 1'b1;
          end
        end
      end
      COLLECT: begin
        byte_ready = 1'b1;
        pk_load    = byte_valid;
        if (byte_valid && pk_last) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        wr_addr = BASE + WORD_W'({index_reg, 2'b00});
        wr_data = pk_word;
        pk_clr  = 1'b1;
        if (index_reg == count_reg - 1'b1) begin
          state_next = RELEASE;
        end else begin
          index_next = index_reg + 1'b1;
          state_next = COLLECT;
        end
      end
      RELEASE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The fetch stage stays in reset for the whole session, so hold tracks busy exactly.
  assign busy     = (state_reg != IDLE);
  assign cpu_hold = busy;
  assign error    = error_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: one default instance and one at ADDR_BASE=0x100, MAX_WORDS=4.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [15:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;

  logic        byte_ready_a, wr_en_a, cpu_hold_a, busy_a, done_a, error_a;
  logic [31:0] wr_addr_a, wr_data_a;
  logic        byte_ready_b, wr_en_b, cpu_hold_b, busy_b, done_b, error_b;
  logic [31:0] wr_addr_b, wr_data_b;

  int checks = 0;
  int failures = 0;

  logic [31:0] a_addr[$], a_data[$], b_addr[$], b_data[$];
  int a_done = 0, a_err = 0, b_done = 0, b_err = 0, inv_err = 0;
  logic prev_done_a = 1'b0, prev_done_b = 1'b0;

  always #5 clk = ~clk;

  instr_mem_loader dut_a (
    .clk(clk), .reset(reset), .start(start_a), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .cpu_hold(cpu_hold_a), .busy(busy_a), .done(done_a), .error(error_a)
  );

  instr_mem_loader #(.ADDR_BASE(32'h100), .MAX_WORDS(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b), .error(error_b)
  );

  // Write log, pulse counters and cycle-by-cycle invariants, sampled away from the edge.
  always @(negedge clk) begin
    if (wr_en_a) begin a_addr.push_back(wr_addr_a); a_data.push_back(wr_data_a); end
    else if (wr_addr_a != 0 || wr_data_a != 0) inv_err++;
    if (wr_en_b) begin b_addr.push_back(wr_addr_b); b_data.push_back(wr_data_b); end
    else if (wr_addr_b != 0 || wr_data_b != 0) inv_err++;
    if (done_a) a_done++;
    if (error_a) a_err++;
    if (done_b) b_done++;
    if (error_b) b_err++;
    if (int'(wr_en_a) + int'(done_a) + int'(error_a) > 1) inv_err++;
    if (int'(wr_en_b) + int'(done_b) + int'(error_b) > 1) inv_err++;
    if (done_a && !cpu_hold_a) inv_err++;
    if (done_b && !cpu_hold_b) inv_err++;
    if (prev_done_a && cpu_hold_a) inv_err++;
    if (prev_done_b && cpu_hold_b) inv_err++;
    if (byte_ready_a && !busy_a) inv_err++;
    prev_done_a = done_a;
    prev_done_b = done_b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    int n = 0;
    while (!(sel ? byte_ready_b : byte_ready_a) && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("byte_ready_timeout", 32'd0, 32'd1);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic pulse_start(input bit sel, input logic [15:0] wc);
    word_count = wc;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    int n = 0;
    while ((sel ? busy_b : busy_a) && n < 400) begin
      tick();
      n++;
    end
    if (n == 400) check("idle_timeout", 32'd0, 32'd1);
  endtask

  int s_w, s_d, s_e;
  time t0, t1;

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    word_count = 16'd0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold_a}, 32'd0);
    check("rst_ready", {31'd0, byte_ready_a}, 32'd0);
    check("rst_wr", {29'd0, wr_en_a, done_a, error_a}, 32'd0);
    check("rst_data", wr_data_a | wr_addr_a, 32'd0);
    reset = 1'b0;
    tick();

    // Two back-to-back words from the reference program
    s_w = a_addr.size(); s_d = a_done;
    pulse_start(1'b0, 16'd2);
    t0 = $time;
    send_byte(0, 8'h00); send_byte(0, 8'h00); send_byte(0, 8'h80); send_byte(0, 8'hD2);
    send_byte(0, 8'h1F); send_byte(0, 8'h20); send_byte(0, 8'h03); send_byte(0, 8'hD5);
    wait_idle(1'b0);
    t1 = $time;
    check("t1_cycles", 32'((t1 - t0) / 10 + 1), 32'd12);
    check("t1_nwr", 32'(a_addr.size() - s_w), 32'd2);
    check("t1_addr0", a_addr[s_w], 32'h0);
    check("t1_data0", a_data[s_w], 32'hD2800000);
    check("t1_addr1", a_addr[s_w+1], 32'h4);
    check("t1_data1", a_data[s_w+1], 32'hD503201F);
    check("t1_done", 32'(a_done - s_d), 32'd1);
    check("t1_hold_after", {31'd0, cpu_hold_a}, 32'd0);

    // Rejected starts: zero and one past capacity
    s_w = a_addr.size(); s_e = a_err;
    pulse_start(1'b0, 16'd0);
    check("t2_busy0", {31'd0, busy_a}, 32'd0);
    tick(); tick();
    pulse_start(1'b0, 16'd257);
    check("t2_busy257", {31'd0, busy_a}, 32'd0);
    tick(); tick();
    check("t2_err", 32'(a_err - s_e), 32'd2);
    check("t2_nwr", 32'(a_addr.size() - s_w), 32'd0);

    // One word with a 3-cycle gap between bytes 1 and 2
    s_w = a_addr.size();
    pulse_start(1'b0, 16'd1);
    send_byte(0, 8'hDD); send_byte(0, 8'hCC);
    for (int i = 0; i < 3; i++) begin
      check("t3_ready_stall", {31'd0, byte_ready_a}, 32'd1);
      check("t3_hold_stall", {31'd0, cpu_hold_a}, 32'd1);
      tick();
    end
    send_byte(0, 8'hBB); send_byte(0, 8'hAA);
    wait_idle(1'b0);
    check("t3_nwr", 32'(a_addr.size() - s_w), 32'd1);
    check("t3_addr", a_addr[s_w], 32'h0);
    check("t3_data", a_data[s_w], 32'hAABBCCDD);

    // Reset after 6 bytes of a 3-word load, then a fresh 1-word session
    s_w = a_addr.size(); s_d = a_done;
    pulse_start(1'b0, 16'd3);
    send_byte(0, 8'h11); send_byte(0, 8'h22); send_byte(0, 8'h33);
    send_byte(0, 8'h44); send_byte(0, 8'h55); send_byte(0, 8'h66);
    reset = 1'b1;
    #1;
    check("t4_busy_rst", {31'd0, busy_a}, 32'd0);
    check("t4_hold_rst", {31'd0, cpu_hold_a}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t4_nwr_before", 32'(a_addr.size() - s_w), 32'd1);
    check("t4_data_kept", a_data[s_w], 32'h44332211);
    pulse_start(1'b0, 16'd1);
    send_byte(0, 8'h78); send_byte(0, 8'h56); send_byte(0, 8'h34); send_byte(0, 8'h12);
    wait_idle(1'b0);
    check("t4_nwr", 32'(a_addr.size() - s_w), 32'd2);
    check("t4_addr", a_addr[s_w+1], 32'h0);
    check("t4_data", a_data[s_w+1], 32'h12345678);
    check("t4_done", 32'(a_done - s_d), 32'd1);

    // Start pulsed mid-session must be ignored
    s_w = a_addr.size(); s_d = a_done; s_e = a_err;
    pulse_start(1'b0, 16'd2);
    send_byte(0, 8'h01); send_byte(0, 8'h02);
    pulse_start(1'b0, 16'd5);
    send_byte(0, 8'h03); send_byte(0, 8'h04);
    send_byte(0, 8'h05); send_byte(0, 8'h06); send_byte(0, 8'h07); send_byte(0, 8'h08);
    wait_idle(1'b0);
    tick();
    check("t5_nwr", 32'(a_addr.size() - s_w), 32'd2);
    check("t5_addr0", a_addr[s_w], 32'h0);
    check("t5_data0", a_data[s_w], 32'h04030201);
    check("t5_addr1", a_addr[s_w+1], 32'h4);
    check("t5_data1", a_data[s_w+1], 32'h08070605);
    check("t5_done", 32'(a_done - s_d), 32'd1);
    check("t5_err", 32'(a_err - s_e), 32'd0);

    // Full-capacity load at ADDR_BASE=0x100, plus a rejected oversize start
    s_e = b_err;
    pulse_start(1'b1, 16'd5);
    tick(); tick();
    check("t6_err", 32'(b_err - s_e), 32'd1);
    check("t6_busy_rej", {31'd0, busy_b}, 32'd0);
    pulse_start(1'b1, 16'd4);
    t0 = $time;
    for (int k = 0; k < 16; k++) send_byte(1, 8'(8'hA0 + k));
    wait_idle(1'b1);
    t1 = $time;
    check("t6_cycles", 32'((t1 - t0) / 10 + 1), 32'd22);
    check("t6_nwr", 32'(b_addr.size()), 32'd4);
    check("t6_first_addr", b_addr[0], 32'h100);
    check("t6_last_addr", b_addr[3], 32'h10C);
    check("t6_last_data", b_data[3], 32'hAFAEADAC);
    check("t6_done", 32'(b_done), 32'd1);
    tick();
    check("t6_hold_after", {31'd0, cpu_hold_b}, 32'd0);

    check("invariants", 32'(inv_err), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter ADDR_BASE, default 0, byte address of the first written instruction; SHALL be a multiple of 4.
REQ-002 Parameter MAX_WORDS, default 256, instruction-memory capacity in words.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to begin a load session; sampled only in IDLE.
REQ-006 word_count  input  16  number of instructions to load; latched on an accepted start.
REQ-007 byte_valid  input  1  byte_data carries a valid byte.
REQ-008 byte_data  input  8  program byte stream.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-011 wr_addr  output  `WORD  byte address of the write.
REQ-012 wr_data  output  `INSTR_LEN  instruction word being written.
REQ-013 cpu_hold  output  1  drives the fetch-stage reset; holds the PC at 0 during loading.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at session completion.
REQ-016 error  output  1  one-cycle pulse on a rejected start.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, COLLECT, WRITE and RELEASE.
REQ-018 IDLE: start=1 with 1<=word_count<=MAX_WORDS -> COLLECT on the next edge; clear the byte counter and word index; latch word_count.
REQ-019 IDLE: start=1 with word_count=0 or word_count>MAX_WORDS -> error=1 for one cycle; remain in IDLE.
REQ-020 byte_ready SHALL be 1 only in COLLECT; a byte is accepted when byte_valid && byte_ready.
REQ-021 Bytes SHALL be packed little-endian: byte k of a word (k=0..3) goes to bits [8k+7:8k].
REQ-022 Acceptance of byte 3 -> WRITE on the next edge; byte_valid=0 in COLLECT stalls with no state change.
REQ-023 WRITE: wr_en=1 for exactly one cycle; wr_addr=ADDR_BASE+4*index (zero-extended to `WORD); wr_data=assembled word.
REQ-024 WRITE: if index==word_count-1 -> RELEASE; otherwise index+1 and -> COLLECT.
REQ-025 RELEASE: done=1 for one cycle, then -> IDLE.
REQ-026 cpu_hold SHALL be 1 in COLLECT, WRITE and RELEASE, and 0 in IDLE, so the CPU leaves reset the cycle after done.
REQ-027 A start asserted while busy SHALL be ignored, with no error pulse.
REQ-028 With an uninterrupted byte stream, a session of N words SHALL take 1+5N+1 cycles, counted from the start edge to the return to IDLE.
REQ-029 wr_en, done and error SHALL never be asserted in the same cycle.
REQ-030 wr_addr and wr_data SHALL be 0 whenever wr_en=0.

Reset
REQ-031 reset SHALL immediately force IDLE, with busy, cpu_hold, wr_en, done, error and byte_ready at 0 and all counters and data at 0.
REQ-032 A reset during a session SHALL abort it; words already written are not rolled back, and a partially assembled word is discarded.

Structure
REQ-033 `WORD and `INSTR_LEN SHALL come from the shared constants.vh; state encodings SHALL be local parameters of this module.
REQ-034 A single sub-module byte_packer (4-byte shift/assemble register with a load counter and clear) SHALL be used; all other logic is inline.

Verification
REQ-035 start, word_count=2, bytes 0x00,0x00,0x80,0xD2,0x1F,0x20,0x03,0xD5 back-to-back -> writes 0xD2800000@0x0 then 0xD503201F@0x4; done pulse; total 12 cycles.
REQ-036 start with word_count=0, then with word_count=MAX_WORDS+1 -> one error pulse each; busy stays 0; no wr_en.
REQ-037 word_count=1 with byte_valid deasserted for 3 cycles between bytes 1 and 2 -> byte_ready held; single write of the correct word; cpu_hold high throughout.
REQ-038 reset asserted after 6 bytes of a 3-word load -> next cycle IDLE, cpu_hold=0; a new 1-word session loads correctly at address ADDR_BASE.
REQ-039 start pulsed again mid-session -> ignored; word count and addresses unchanged; exactly one done.
REQ-040 ADDR_BASE=0x100, word_count=MAX_WORDS -> last write at 0x100+4*(MAX_WORDS-1); cpu_hold falls one cycle after done.
